// File: rtl/ocp_tgt_pkg.sv
// Shared types for the OCP target memory: command/response encodings,
// the request queue entry and the front-end/back-end state encodings.
package ocp_tgt_pkg;

    // Widths of the fields carried through the request queue; the top-level
    // AW/DW parameters are expected to match these.
    localparam int OCP_AW = 32;
    localparam int OCP_DW = 32;

    typedef enum logic [2:0] {
        CMD_IDLE = 3'b000,
        CMD_WR   = 3'b001,
        CMD_RD   = 3'b010
    } ocp_cmd_e;

    typedef enum logic [1:0] {
        RESP_NULL = 2'b00,
        RESP_DVA  = 2'b01,
        RESP_ERR  = 2'b11
    } ocp_resp_e;

    // cmd is kept as raw bits so illegal encodings survive the queue and can
    // be answered with an error response by the back-end.
    typedef struct packed {
        logic [2:0]        cmd;
        logic [2:0]        tag;
        logic [OCP_AW-1:0] addr;
        logic [OCP_DW-1:0] data;
    } req_entry_t;

    typedef enum logic {
        F_CMD,
        F_WDATA
    } front_state_e;

    typedef enum logic [1:0] {
        B_IDLE,
        B_WAIT,
        B_RESP
    } back_state_e;

endpackage

// File: rtl/ocp_tgt_req_fifo.sv
// Synchronous request queue between the OCP front-end and the memory engine.
// FIFO_DEPTH must be a power of two so the pointers wrap naturally.
module ocp_tgt_req_fifo
    import ocp_tgt_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  req_entry_t                  push_data,
    input  logic                        pop,
    output req_entry_t                  head,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(FIFO_DEPTH):0] count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] CAPACITY = FIFO_DEPTH[PW:0];

    req_entry_t    slots [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == CAPACITY);
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = slots[rd_ptr];

    // Entry storage; contents need no reset because count guards validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            slots[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; push and pop together leave count alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ocp_target_mem.sv
// OCP slave endpoint: queues incoming requests and serves them in order from
// a local word-addressed memory, returning tagged responses.
// Build option OCP_TGT_WRESP_EN: when defined, in-range writes also return a
// DVA response; otherwise writes are posted and silent.
module ocp_target_mem
    import ocp_tgt_pkg::*;
#(
    parameter int AW         = OCP_AW,
    parameter int DW         = OCP_DW,
    parameter int DEPTH      = 1024,
    parameter int FIFO_DEPTH = 4,
    parameter int RD_LAT     = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    MCmd,
    input  logic [AW-1:0] MAddr,
    input  logic [2:0]    MTagID,
    input  logic [DW-1:0] Mdata,
    input  logic          MDataValid,
    input  logic          MRespAccept,
    output logic          SCmdAccept,
    output logic          SDataAccept,
    output logic [1:0]    SResp,
    output logic [DW-1:0] SData,
    output logic [2:0]    STagID
);

    localparam int IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW     = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam int CW     = $clog2(FIFO_DEPTH) + 1;
    localparam int LAT_M1 = RD_LAT - 1;
    localparam logic [AW-3:0] DEPTH_WORDS = DEPTH[AW-3:0];
    localparam logic [LW-1:0] LAT_LOAD    = LAT_M1[LW-1:0];
    localparam logic [CW-1:0] FIFO_CAP    = FIFO_DEPTH[CW-1:0];

`ifdef OCP_TGT_WRESP_EN
    localparam logic WR_RESPONDS = 1'b1;
`else
    localparam logic WR_RESPONDS = 1'b0;
`endif

    logic [DW-1:0] mem [DEPTH];

    front_state_e  f_state;
    front_state_e  f_next;
    back_state_e   b_state;
    back_state_e   b_next;

    req_entry_t    push_data;
    req_entry_t    head;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;

    logic          can_accept;
    logic          cmd_take;
    logic [2:0]    wr_tag;
    logic [AW-1:0] wr_addr;

    logic [AW-3:0] head_idx;
    logic          head_in_range;
    logic          head_rd;
    logic          head_wr;
    logic          head_err;
    logic          mem_we;
    logic [IW-1:0] rd_idx;
    logic [LW-1:0] lat_cnt;
    logic          unused_addr_bits;

    ocp_tgt_req_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    assign can_accept = !rst && (count < FIFO_CAP);
    assign cmd_take   = (f_state == F_CMD) && can_accept && (MCmd != CMD_IDLE);

    assign head_idx         = head.addr[AW-1:2];
    assign head_in_range    = (head_idx < DEPTH_WORDS);
    assign head_rd          = (head.cmd == CMD_RD);
    assign head_wr          = (head.cmd == CMD_WR);
    assign head_err         = !(head_rd || head_wr) || !head_in_range;
    assign unused_addr_bits = ^{head.addr[1:0], full};

    // Front-end state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_state <= F_CMD;
        end else begin
            f_state <= f_next;
        end
    end

    // Front-end next state: a write command waits for its data phase.
    always_comb begin
        f_next = f_state;
        case (f_state)
            F_CMD:   if (cmd_take && (MCmd == CMD_WR)) f_next = F_WDATA;
            F_WDATA: if (MDataValid) f_next = F_CMD;
            default: f_next = F_CMD;
        endcase
    end

    // Front-end outputs and queue pushes; the data phase ignores MCmd.
    always_comb begin
        SCmdAccept  = 1'b0;
        SDataAccept = 1'b0;
        push        = 1'b0;
        push_data   = '0;
        case (f_state)
            F_CMD: begin
                SCmdAccept = can_accept;
                if (cmd_take && (MCmd != CMD_WR)) begin
                    push           = 1'b1;
                    push_data.cmd  = MCmd;
                    push_data.tag  = MTagID;
                    push_data.addr = MAddr;
                end
            end
            F_WDATA: begin
                SDataAccept = !rst;
                if (MDataValid) begin
                    push           = 1'b1;
                    push_data.cmd  = CMD_WR;
                    push_data.tag  = wr_tag;
                    push_data.addr = wr_addr;
                    push_data.data = Mdata;
                end
            end
            default: ;
        endcase
    end

    // Hold the write command's tag and address until its data arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_tag  <= '0;
            wr_addr <= '0;
        end else if (cmd_take && (MCmd == CMD_WR)) begin
            wr_tag  <= MTagID;
            wr_addr <= MAddr;
        end
    end

    // Back-end state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_state <= B_IDLE;
        end else begin
            b_state <= b_next;
        end
    end

    // Back-end next state: errors respond at once, reads wait out the latency.
    always_comb begin
        b_next = b_state;
        case (b_state)
            B_IDLE: begin
                if (!empty) begin
                    if (head_err) begin
                        b_next = B_RESP;
                    end else if (head_rd) begin
                        b_next = B_WAIT;
                    end else if (WR_RESPONDS) begin
                        b_next = B_RESP;
                    end
                end
            end
            B_WAIT:  if (lat_cnt == '0) b_next = B_RESP;
            B_RESP:  if (MRespAccept) b_next = B_IDLE;
            default: b_next = B_IDLE;
        endcase
    end

    // Back-end outputs: pop only from idle, write memory on the pop edge.
    always_comb begin
        pop    = (b_state == B_IDLE) && !empty;
        mem_we = pop && head_wr && head_in_range;
    end

    // Memory array; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[head_idx[IW-1:0]] <= head.data;
        end
    end

    // Response registers and read-latency counter; outputs stay stable in B_RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            SResp   <= RESP_NULL;
            SData   <= '0;
            STagID  <= '0;
            rd_idx  <= '0;
            lat_cnt <= '0;
        end else begin
            case (b_state)
                B_IDLE: begin
                    if (pop) begin
                        STagID  <= head.tag;
                        rd_idx  <= head_idx[IW-1:0];
                        lat_cnt <= LAT_LOAD;
                        if (head_err) begin
                            SResp <= RESP_ERR;
                            SData <= '0;
                        end else if (head_wr && WR_RESPONDS) begin
                            SResp <= RESP_DVA;
                            SData <= '0;
                        end
                    end
                end
                B_WAIT: begin
                    if (lat_cnt == '0) begin
                        SResp <= RESP_DVA;
                        SData <= mem[rd_idx];
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                B_RESP: begin
                    if (MRespAccept) begin
                        SResp <= RESP_NULL;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ocp_target_mem.sv
// Randomised scoreboard bench for ocp_target_mem: requests push their
// expected responses into a queue, a monitor pops and compares them.
module tb_ocp_target_mem;
    import ocp_tgt_pkg::*;

    localparam int AW         = 32;
    localparam int DW         = 32;
    localparam int DEPTH      = 1024;
    localparam int FIFO_DEPTH = 4;
    localparam int RD_LAT     = 2;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
        logic [2:0]  tag;
        bit          chk_data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [2:0]    MCmd = 3'b000;
    logic [AW-1:0] MAddr = '0;
    logic [2:0]    MTagID = '0;
    logic [DW-1:0] Mdata = '0;
    logic          MDataValid = 1'b0;
    logic          MRespAccept = 1'b0;
    logic          SCmdAccept;
    logic          SDataAccept;
    logic [1:0]    SResp;
    logic [DW-1:0] SData;
    logic [2:0]    STagID;

    exp_t          exp_q[$];
    logic [31:0]   ref_mem [DEPTH];
    bit            ref_valid [DEPTH];
    int            total = 0;
    int            bad = 0;
    int            acc_mode = 1;

    ocp_target_mem #(
        .AW(AW), .DW(DW), .DEPTH(DEPTH), .FIFO_DEPTH(FIFO_DEPTH), .RD_LAT(RD_LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .MCmd        (MCmd),
        .MAddr       (MAddr),
        .MTagID      (MTagID),
        .Mdata       (Mdata),
        .MDataValid  (MDataValid),
        .MRespAccept (MRespAccept),
        .SCmdAccept  (SCmdAccept),
        .SDataAccept (SDataAccept),
        .SResp       (SResp),
        .SData       (SData),
        .STagID      (STagID)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic bit addr_in_range(input logic [31:0] a);
        logic [31:0] w;
        w = a >> 2;
        return w < 32'(DEPTH);
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'(a >> 2);
    endfunction

    function automatic void push_exp(input logic [1:0] resp, input logic [31:0] data,
                                     input logic [2:0] tag, input bit chk);
        exp_t e;
        e.resp = resp;
        e.data = data;
        e.tag = tag;
        e.chk_data = chk;
        exp_q.push_back(e);
    endfunction

    // Reference behaviour for a command (non-write) at the moment it is accepted.
    function automatic void model_cmd(input logic [2:0] cmd, input logic [31:0] addr, input logic [2:0] tag);
        if (cmd == CMD_RD && addr_in_range(addr)) begin
            push_exp(RESP_DVA, ref_mem[word_of(addr)], tag, ref_valid[word_of(addr)]);
        end else begin
            push_exp(RESP_ERR, 32'h0, tag, 1'b1);
        end
    endfunction

    // Reference behaviour for a write at the moment its data is accepted.
    function automatic void model_write(input logic [31:0] addr, input logic [2:0] tag, input logic [31:0] data);
        if (addr_in_range(addr)) begin
            ref_mem[word_of(addr)] = data;
            ref_valid[word_of(addr)] = 1'b1;
`ifdef OCP_TGT_WRESP_EN
            push_exp(RESP_DVA, 32'h0, tag, 1'b1);
`endif
        end else begin
            push_exp(RESP_ERR, 32'h0, tag, 1'b1);
        end
    endfunction

    // Issue one request; writes follow with their data phase after dly cycles.
    task automatic applyStimulus(input logic [2:0] cmd, input logic [31:0] addr, input logic [2:0] tag,
                                 input logic [31:0] data, input int dly);
        int n;
        MCmd = cmd;
        MAddr = addr;
        MTagID = tag;
        n = 0;
        @(negedge clk);
        while (!SCmdAccept) begin
            n++;
            if (n > 300) begin
                total++;
                bad++;
                $display("[TB] FAIL cmd_accept_timeout: got no SCmdAccept, expected one within 300 cycles");
                MCmd = CMD_IDLE;
                return;
            end
            @(negedge clk);
        end
        if (cmd != CMD_WR) model_cmd(cmd, addr, tag);
        @(posedge clk);
        #1;
        MCmd = CMD_IDLE;
        if (cmd == CMD_WR) begin
            repeat (dly) begin
                @(negedge clk);
                checkOutput("wdata_wait_scmdaccept", 32'(SCmdAccept), 32'h0);
                checkOutput("wdata_wait_sdataaccept", 32'(SDataAccept), 32'h1);
                @(posedge clk);
                #1;
            end
            Mdata = data;
            MDataValid = 1'b1;
            n = 0;
            @(negedge clk);
            while (!SDataAccept) begin
                n++;
                if (n > 50) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL data_accept_timeout: got no SDataAccept, expected one within 50 cycles");
                    MDataValid = 1'b0;
                    return;
                end
                @(negedge clk);
            end
            model_write(addr, tag, data);
            @(posedge clk);
            #1;
            MDataValid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain_timeout: got %0d responses outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // Response acceptance driver: hold low, hold high or random per cycle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (acc_mode)
                0:       MRespAccept = 1'b0;
                1:       MRespAccept = 1'b1;
                default: MRespAccept = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: compare each response on the cycle the master accepts it.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && SResp != RESP_NULL && MRespAccept) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_resp: got SResp=%0d tag=%0d, expected no response", SResp, STagID);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("resp_code", 32'(SResp), 32'(e.resp));
                    checkOutput("resp_tag", 32'(STagID), 32'(e.tag));
                    if (e.chk_data) checkOutput("resp_data", SData, e.data);
                end
            end
        end
    end

    initial begin : main
        int n;
        logic [2:0]  cmd;
        logic [31:0] addr;
        int          r;

        // Reset values
        #2;
        checkOutput("reset_scmdaccept", 32'(SCmdAccept), 32'h0);
        checkOutput("reset_sdataaccept", 32'(SDataAccept), 32'h0);
        checkOutput("reset_sresp", 32'(SResp), 32'h0);
        checkOutput("reset_sdata", SData, 32'h0);
        checkOutput("reset_stagid", 32'(STagID), 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Write then read with latency measurement
        applyStimulus(CMD_WR, 32'h10, 3'd3, 32'hDEADBEEF, 0);
        drain();
        applyStimulus(CMD_RD, 32'h10, 3'd5, 32'h0, 0);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (SResp == RESP_NULL && n < 20);
        checkOutput("read_latency", 32'(n), 32'(1 + RD_LAT));
        drain();

        // Out of range read and write; word 0 must not be clobbered by index aliasing
        applyStimulus(CMD_WR, 32'h0, 3'd1, 32'h12345678, 0);
        applyStimulus(CMD_WR, 32'h1000, 3'd2, 32'hBAD0BAD0, 0);
        applyStimulus(CMD_RD, 32'h1000, 3'd3, 32'h0, 0);
        applyStimulus(CMD_RD, 32'h0, 3'd4, 32'h0, 0);
        drain();

        // Delayed write data, then read it back; also an illegal command
        applyStimulus(CMD_WR, 32'h20, 3'd6, 32'hCAFEF00D, 3);
        applyStimulus(CMD_RD, 32'h20, 3'd7, 32'h0, 0);
        applyStimulus(3'b101, 32'h10, 3'd1, 32'h0, 0);
        drain();

        // Back-pressure: five accepted while responses are blocked, sixth waits
        acc_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        for (int t = 0; t < 5; t++) begin
            applyStimulus(CMD_RD, 32'h10, 3'(t), 32'h0, 0);
        end
        repeat (3) begin
            @(negedge clk);
            checkOutput("full_scmdaccept", 32'(SCmdAccept), 32'h0);
        end
        acc_mode = 1;
        applyStimulus(CMD_RD, 32'h20, 3'd5, 32'h0, 0);
        drain();

        // Reset while a read is waiting on memory latency
        applyStimulus(CMD_RD, 32'h10, 3'd2, 32'h0, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        #1;
        checkOutput("midreset_sresp", 32'(SResp), 32'h0);
        checkOutput("midreset_scmdaccept", 32'(SCmdAccept), 32'h0);
        checkOutput("midreset_stagid", 32'(STagID), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("postreset_sresp", 32'(SResp), 32'h0);
        applyStimulus(CMD_RD, 32'h10, 3'd4, 32'h0, 0);
        drain();

`ifdef OCP_TGT_WRESP_EN
        // Write response held until accepted
        acc_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        applyStimulus(CMD_WR, 32'h30, 3'd6, 32'h0BADCAFE, 0);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("wresp_held_code", 32'(SResp), 32'(RESP_DVA));
        checkOutput("wresp_held_tag", 32'(STagID), 32'h6);
        acc_mode = 1;
        drain();
`endif

        // Random traffic against the reference model
        acc_mode = 2;
        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 9);
            if ($urandom_range(0, 1) == 1)
                addr = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            else
                addr = ($urandom_range(1020, 1023) << 2) | $urandom_range(0, 3);
            if (r <= 3) begin
                cmd = CMD_WR;
            end else if (r <= 7) begin
                cmd = CMD_RD;
            end else if (r == 8) begin
                cmd = 3'($urandom_range(3, 7));
            end else begin
                cmd = ($urandom_range(0, 1) == 1) ? CMD_WR : CMD_RD;
                addr = $urandom_range(1024, 1100) << 2;
            end
            applyStimulus(cmd, addr, 3'($urandom_range(0, 7)), $urandom, $urandom_range(0, 2));
        end
        acc_mode = 1;
        drain();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("final_idle_sresp", 32'(SResp), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
